wb_regfile: RTL and testbench

Writeback stage and integer register file for the RV32 pipeline. Consumes the MEM/WB pipeline register outputs, selects the writeback value, aligns and extends load data, and commits it to a 32×32 register file. It exposes two combinational read ports to decode and stalls the pipeline while a load's data is outstanding.

---
 rtl/wb_regfile_if.sv | 40 ++++
 rtl/wb_regfile.sv | 171 +++++++++++++++++
 tb/tb_wb_regfile.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_regfile_if.sv
// Bus bundle between the MEM/WB pipeline register / decode stage and wb_regfile.
// The master modport is the pipeline side; the slave modport is the writeback/register-file side.
interface wb_regfile_if;
  logic        start;
  logic        lui_in;
  logic        auipc_in;
  logic        mem_to_reg_in;
  logic        reg_write_in;
  logic [31:0] inst_in;
  logic [31:0] j_type_in;
  logic [31:0] u_type_in;
  logic [31:0] alu_result_in;
  logic [31:0] ld_data_in;
  logic        ld_valid_in;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        wb_stall;
  logic        ld_err;
  logic        retire_valid;
  logic [4:0]  retire_rd;
  logic [31:0] retire_data;

  modport master (
    output start, lui_in, auipc_in, mem_to_reg_in, reg_write_in, inst_in,
           j_type_in, u_type_in, alu_result_in, ld_data_in, ld_valid_in,
           rs1_addr, rs2_addr,
    input  rs1_data, rs2_data, wb_stall, ld_err,
           retire_valid, retire_rd, retire_data
  );

  modport slave (
    input  start, lui_in, auipc_in, mem_to_reg_in, reg_write_in, inst_in,
           j_type_in, u_type_in, alu_result_in, ld_data_in, ld_valid_in,
           rs1_addr, rs2_addr,
    output rs1_data, rs2_data, wb_stall, ld_err,
           retire_valid, retire_rd, retire_data
  );
endinterface

// File: rtl/wb_regfile.sv
// RV32 writeback stage and 32x32 register file with load-wait stall and timeout.
// Optional macro WB_BYPASS_EN: same-cycle write-through on the read ports.
module wb_regfile #(
  parameter int LD_TIMEOUT = 16
) (
  input logic         clk,
  input logic         reset,
  wb_regfile_if.slave bus
);

  localparam int CW = (LD_TIMEOUT > 1) ? $clog2(LD_TIMEOUT + 1) : 1;

  typedef enum logic {RUN, WAIT_LD} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [31:0]     regs_q [32];
  logic            retireValid_q;
  logic [4:0]      retireRd_q;
  logic [31:0]     retireData_q;

  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [1:0]  off;
  logic [7:0]  loadByte;
  logic [15:0] loadHalf;
  logic [31:0] loadWord;
  logic [31:0] wrData;
  logic        loadPending;
  logic        commitEnable;
  logic        timeoutHit;
  logic        commit;
  logic        stallRaw;
  logic        unusedInstBits;

  assign opcode         = bus.inst_in[6:0];
  assign rd             = bus.inst_in[11:7];
  assign funct3         = bus.inst_in[14:12];
  assign off            = bus.alu_result_in[1:0];
  assign unusedInstBits = ^bus.inst_in[31:15];

  assign loadPending  = bus.start & bus.reg_write_in & bus.mem_to_reg_in;
  assign commitEnable = bus.start & bus.reg_write_in & (rd != 5'd0)
                      & (~bus.mem_to_reg_in | bus.ld_valid_in);
  assign timeoutHit   = (cnt_q == CW'(LD_TIMEOUT - 1));

  // Little-endian load alignment; unknown funct3 codes behave like LW.
  always_comb begin
    loadByte = bus.ld_data_in[7:0];
    unique case (off)
      2'd0: loadByte = bus.ld_data_in[7:0];
      2'd1: loadByte = bus.ld_data_in[15:8];
      2'd2: loadByte = bus.ld_data_in[23:16];
      2'd3: loadByte = bus.ld_data_in[31:24];
    endcase
    loadHalf = off[1] ? bus.ld_data_in[31:16] : bus.ld_data_in[15:0];
    unique case (funct3)
      3'b000:  loadWord = {{24{loadByte[7]}}, loadByte};
      3'b001:  loadWord = {{16{loadHalf[15]}}, loadHalf};
      3'b100:  loadWord = {24'd0, loadByte};
      3'b101:  loadWord = {16'd0, loadHalf};
      default: loadWord = bus.ld_data_in;
    endcase
  end

  always_comb begin
    if (bus.mem_to_reg_in)
      wrData = loadWord;
    else if (bus.lui_in || bus.auipc_in)
      wrData = bus.u_type_in;
    else if (opcode == 7'b1101111 || opcode == 7'b1100111)
      wrData = bus.j_type_in;
    else
      wrData = bus.alu_result_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Leaving WAIT_LD happens on valid data, on abort, or on the final timeout cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      RUN: begin
        if (loadPending && !bus.ld_valid_in) begin
          state_d = WAIT_LD;
          cnt_d   = '0;
        end
      end
      WAIT_LD: begin
        if (!loadPending || bus.ld_valid_in) begin
          state_d = RUN;
        end else if (timeoutHit) begin
          state_d = RUN;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase
  end

  always_comb begin
    stallRaw = 1'b0;
    commit   = 1'b0;
    unique case (state_q)
      RUN: begin
        stallRaw = loadPending & ~bus.ld_valid_in;
        commit   = commitEnable;
      end
      WAIT_LD: begin
        if (loadPending) begin
          commit   = commitEnable & bus.ld_valid_in;
          stallRaw = ~bus.ld_valid_in & ~timeoutHit;
        end
      end
    endcase
  end

  assign bus.wb_stall = reset & stallRaw;
  assign bus.ld_err   = err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (commit) begin
      regs_q[rd] <= wrData;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retireValid_q <= 1'b0;
      retireRd_q    <= '0;
      retireData_q  <= '0;
    end else begin
      retireValid_q <= commit;
      retireRd_q    <= commit ? rd : 5'd0;
      retireData_q  <= commit ? wrData : 32'd0;
    end
  end

  assign bus.retire_valid = retireValid_q;
  assign bus.retire_rd    = retireRd_q;
  assign bus.retire_data  = retireData_q;

  always_comb begin
    bus.rs1_data = regs_q[bus.rs1_addr];
    bus.rs2_data = regs_q[bus.rs2_addr];
`ifdef WB_BYPASS_EN
    if (commit && rd == bus.rs1_addr) bus.rs1_data = wrData;
    if (commit && rd == bus.rs2_addr) bus.rs2_data = wrData;
`endif
    if (bus.rs1_addr == 5'd0) bus.rs1_data = '0;
    if (bus.rs2_addr == 5'd0) bus.rs2_data = '0;
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed cases followed by randomized
// writes and loads compared against an array-based architectural model.
module tb_wb_regfile;

  localparam int LD_TIMEOUT = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  wb_regfile_if bus();

  wb_regfile #(.LD_TIMEOUT(LD_TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          checkCount = 0;
  int          errorCount = 0;
  logic [31:0] model [32];
  logic        modelErr;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Expected load value from byte-lane arithmetic on the raw word.
  function automatic logic [31:0] loadModel(input logic [31:0] word, input logic [2:0] f3, input logic [1:0] off);
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    shifted = word >> (int'(off) * 8);
    b = shifted[7:0];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  return 32'(int'($signed(b)));
      3'b001:  return 32'(int'($signed(h)));
      3'b100:  return 32'(b);
      3'b101:  return 32'(h);
      default: return word;
    endcase
  endfunction

  task automatic idleInputs();
    bus.start         = 1'b0;
    bus.lui_in        = 1'b0;
    bus.auipc_in      = 1'b0;
    bus.mem_to_reg_in = 1'b0;
    bus.reg_write_in  = 1'b0;
    bus.inst_in       = '0;
    bus.j_type_in     = '0;
    bus.u_type_in     = '0;
    bus.alu_result_in = '0;
    bus.ld_data_in    = '0;
    bus.ld_valid_in   = 1'b0;
  endtask

  task automatic checkRetire(input logic v, input logic [4:0] rd, input logic [31:0] d);
    checkOutput("retire_valid", 32'(bus.retire_valid), 32'(v));
    checkOutput("retire_rd", 32'(bus.retire_rd), 32'(rd));
    checkOutput("retire_data", bus.retire_data, d);
  endtask

  task automatic checkReads();
    logic [4:0] a, b;
    a = 5'($urandom);
    b = 5'($urandom);
    bus.rs1_addr = a;
    bus.rs2_addr = b;
    #1;
    checkOutput("rs1_read", bus.rs1_data, model[a]);
    checkOutput("rs2_read", bus.rs2_data, model[b]);
  endtask

  // kind: 0 ALU, 1 LUI, 2 AUIPC (with a JALR opcode to exercise priority), 3 JAL/JALR link.
  task automatic applyStimulus(input int kind, input logic [4:0] rd, input logic [31:0] value);
    logic [31:0] expRead;
    @(negedge clk);
    idleInputs();
    bus.start         = 1'b1;
    bus.reg_write_in  = 1'b1;
    bus.alu_result_in = $urandom;
    bus.u_type_in     = $urandom;
    bus.j_type_in     = $urandom;
    bus.ld_data_in    = $urandom;
    bus.ld_valid_in   = 1'($urandom);
    bus.inst_in       = {17'($urandom), 3'($urandom), rd, 7'b0110011};
    case (kind)
      1: begin bus.lui_in = 1'b1; bus.u_type_in = value; end
      2: begin bus.auipc_in = 1'b1; bus.u_type_in = value; bus.inst_in[6:0] = 7'b1100111; end
      3: begin bus.j_type_in = value; bus.inst_in[6:0] = ($urandom_range(0, 1) == 0) ? 7'b1101111 : 7'b1100111; end
      default: bus.alu_result_in = value;
    endcase
    bus.rs2_addr = rd;
    #1;
    checkOutput("stall_on_alu", 32'(bus.wb_stall), 32'd0);
`ifdef WB_BYPASS_EN
    expRead = (rd == 5'd0) ? 32'd0 : value;
`else
    expRead = model[rd];
`endif
    checkOutput("same_cycle_rs2", bus.rs2_data, expRead);
    @(posedge clk);
    if (rd != 5'd0) model[rd] = value;
    #1;
    checkRetire(rd != 5'd0, rd, (rd != 5'd0) ? value : 32'd0);
    @(negedge clk);
    idleInputs();
  endtask

  task automatic applyLoad(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off,
                           input logic [31:0] word, input int late, input logic never);
    int          stalls;
    logic        done;
    logic        doCommit;
    logic [31:0] expected;
    @(negedge clk);
    idleInputs();
    bus.start         = 1'b1;
    bus.reg_write_in  = 1'b1;
    bus.mem_to_reg_in = 1'b1;
    bus.lui_in        = 1'($urandom);
    bus.u_type_in     = $urandom;
    bus.inst_in       = {17'($urandom), f3, rd, 7'b0000011};
    bus.alu_result_in = {30'($urandom), off};
    bus.ld_data_in    = word;
    bus.ld_valid_in   = !never && late == 0;
    stalls = 0;
    done   = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      #1;
      if (!bus.wb_stall) begin
        done = 1'b1;
      end else begin
        stalls++;
        @(posedge clk);
        @(negedge clk);
        if (!never && stalls == late) bus.ld_valid_in = 1'b1;
      end
    end
    checkOutput("stall_bound", 32'(done), 32'd1);
    checkOutput("stall_cycles", 32'(stalls), never ? 32'(LD_TIMEOUT) : 32'(late));
    expected = loadModel(word, f3, off);
    doCommit = !never && rd != 5'd0;
    @(posedge clk);
    if (doCommit) model[rd] = expected;
    if (never) modelErr = 1'b1;
    #1;
    checkRetire(doCommit, doCommit ? rd : 5'd0, doCommit ? expected : 32'd0);
    checkOutput("ld_err", 32'(bus.ld_err), 32'(modelErr));
    @(negedge clk);
    idleInputs();
  endtask

  task automatic applyAbort(input logic [4:0] rd);
    @(negedge clk);
    idleInputs();
    bus.start         = 1'b1;
    bus.reg_write_in  = 1'b1;
    bus.mem_to_reg_in = 1'b1;
    bus.inst_in       = {17'd0, 3'b010, rd, 7'b0000011};
    bus.ld_data_in    = $urandom;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    checkOutput("abort_stall", 32'(bus.wb_stall), 32'd0);
    @(posedge clk);
    #1;
    checkRetire(1'b0, 5'd0, 32'd0);
    checkOutput("abort_ld_err", 32'(bus.ld_err), 32'(modelErr));
    @(negedge clk);
    idleInputs();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 32; i++) model[i] = '0;
    modelErr = 1'b0;
    idleInputs();
    bus.rs1_addr = '0;
    bus.rs2_addr = '0;
    bus.start         = 1'b1;
    bus.reg_write_in  = 1'b1;
    bus.mem_to_reg_in = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("stall_in_reset", 32'(bus.wb_stall), 32'd0);
    idleInputs();
    reset = 1'b1;
    #1;
    checkRetire(1'b0, 5'd0, 32'd0);
    checkOutput("reset_ld_err", 32'(bus.ld_err), 32'd0);
    for (int r = 0; r < 32; r++) begin
      bus.rs1_addr = 5'(r);
      bus.rs2_addr = 5'(31 - r);
      #1;
      checkOutput("reset_rs1", bus.rs1_data, 32'd0);
      checkOutput("reset_rs2", bus.rs2_data, 32'd0);
    end

    applyStimulus(0, 5'd5, 32'h1234_5678);
    bus.rs1_addr = 5'd5; #1;
    checkOutput("x5_alu", bus.rs1_data, 32'h1234_5678);

    applyStimulus(0, 5'd0, 32'hFFFF_FFFF);
    bus.rs1_addr = 5'd0; #1;
    checkOutput("x0_zero", bus.rs1_data, 32'd0);

    applyLoad(5'd10, 3'b000, 2'd1, 32'h8081_F2A3, 0, 1'b0);
    applyLoad(5'd11, 3'b100, 2'd1, 32'h8081_F2A3, 0, 1'b0);
    applyLoad(5'd12, 3'b001, 2'd2, 32'h8081_F2A3, 0, 1'b0);
    applyLoad(5'd13, 3'b101, 2'd2, 32'h8081_F2A3, 0, 1'b0);
    bus.rs1_addr = 5'd10; bus.rs2_addr = 5'd11; #1;
    checkOutput("lb", bus.rs1_data, 32'hFFFF_FFF2);
    checkOutput("lbu", bus.rs2_data, 32'h0000_00F2);
    bus.rs1_addr = 5'd12; bus.rs2_addr = 5'd13; #1;
    checkOutput("lh", bus.rs1_data, 32'hFFFF_8081);
    checkOutput("lhu", bus.rs2_data, 32'h0000_8081);

    applyLoad(5'd14, 3'b010, 2'd0, 32'hDEAD_BEEF, 3, 1'b0);
    bus.rs1_addr = 5'd14; #1;
    checkOutput("late_lw", bus.rs1_data, 32'hDEAD_BEEF);

    applyLoad(5'd15, 3'b010, 2'd0, 32'h5555_AAAA, 0, 1'b1);
    bus.rs1_addr = 5'd15; #1;
    checkOutput("timeout_no_write", bus.rs1_data, 32'd0);

    applyStimulus(1, 5'd7, 32'h1111_0000);
    applyStimulus(0, 5'd7, 32'hCAFE_0001);
    applyStimulus(2, 5'd8, 32'h0000_3000);
    applyStimulus(3, 5'd9, 32'h0000_0104);
    applyAbort(5'd9);
    checkReads();

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        applyLoad(5'($urandom), 3'($urandom), 2'($urandom), $urandom,
                  int'($urandom_range(0, 3)), $urandom_range(0, 5) == 0);
      end else begin
        applyStimulus(int'($urandom_range(0, 3)), 5'($urandom), $urandom);
      end
      checkReads();
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
